// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide FSM encoding and sizing constants.
package cpu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned ITER          = 32;
    localparam int unsigned COUNT_W       = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and restoring divide into HI/LO.
// Optional divide-by-zero trap enabled by defining MULTDIV_DIV0_TRAP_EN.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mult_start,
    input  logic             div_start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    md_state_e          state_q;
    logic [COUNT_W-1:0] count_q;
    // acc/q/qm1 form the Booth {acc, Q, q-1} register; in DIV acc is the remainder, q the quotient.
    logic [WIDTH-1:0]   acc_q, q_q, m_q;
    logic               qm1_q, a_neg_q, q_neg_q;

    logic [WIDTH:0]     acc_ext, m_ext, booth_sum;
    logic [WIDTH-1:0]   booth_acc, booth_q, a_abs, b_abs, div_rem, fix_quot, fix_rem;
    logic               div_qbit, last_step;

    // One guard bit on the add keeps the most-negative multiplicand from overflowing.
    always_comb begin
        acc_ext = {acc_q[WIDTH-1], acc_q};
        m_ext   = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_ext + m_ext;
            2'b10:   booth_sum = acc_ext - m_ext;
            default: booth_sum = acc_ext;
        endcase
        booth_acc = booth_sum[WIDTH:1];
        booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
    end

    assign a_abs     = a_in[WIDTH-1] ? '0 - a_in : a_in;
    assign b_abs     = b_in[WIDTH-1] ? '0 - b_in : b_in;
    assign fix_quot  = q_neg_q ? '0 - q_q : q_q;
    assign fix_rem   = a_neg_q ? '0 - acc_q : acc_q;
    assign last_step = (count_q == COUNT_W'(ITER - 1));

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in      (acc_q),
        .dividend_bit(q_q[WIDTH-1]),
        .divisor     (m_q),
        .rem_out     (div_rem),
        .q_bit       (div_qbit)
    );

`ifdef MULTDIV_DIV0_TRAP_EN
    logic div_zero_q, dz_pending_q;
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
`ifdef MULTDIV_DIV0_TRAP_EN
            div_zero_q   <= 1'b0;
            dz_pending_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULTDIV_DIV0_TRAP_EN
            div_zero_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mult_start) begin
                        state_q <= MULT;
                        busy    <= 1'b1;
                        count_q <= '0;
                        acc_q   <= '0;
                        q_q     <= a_in;
                        qm1_q   <= 1'b0;
                        m_q     <= b_in;
                    end else if (div_start) begin
                        busy    <= 1'b1;
                        count_q <= '0;
                        acc_q   <= '0;
                        q_q     <= a_abs;
                        m_q     <= b_abs;
                        a_neg_q <= a_in[WIDTH-1];
                        q_neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
`ifdef MULTDIV_DIV0_TRAP_EN
                        // Zero divisor skips the iterations; one FIX cycle sets up the flag.
                        if (b_in == '0) begin
                            state_q      <= FIX;
                            dz_pending_q <= 1'b1;
                        end else begin
                            state_q <= DIV;
                        end
`else
                        state_q <= DIV;
`endif
                    end
                end
                MULT: begin
                    acc_q   <= booth_acc;
                    q_q     <= booth_q;
                    qm1_q   <= q_q[0];
                    count_q <= count_q + 1'b1;
                    if (last_step) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        hi_out  <= booth_acc;
                        lo_out  <= booth_q;
                    end
                end
                DIV: begin
                    acc_q   <= div_rem;
                    q_q     <= {q_q[WIDTH-2:0], div_qbit};
                    count_q <= count_q + 1'b1;
                    if (last_step) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
`ifdef MULTDIV_DIV0_TRAP_EN
                    dz_pending_q <= 1'b0;
                    if (dz_pending_q) begin
                        div_zero_q <= 1'b1;
                    end else begin
                        hi_out <= fix_rem;
                        lo_out <= fix_quot;
                    end
`else
                    hi_out <= fix_rem;
                    lo_out <= fix_quot;
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit; follows MULTDIV_DIV0_TRAP_EN like the design.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_in, b_in;
    logic        mult_start, div_start;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .a_in      (a_in),
        .b_in      (b_in),
        .mult_start(mult_start),
        .div_start (div_start),
        .busy      (busy),
        .done      (done),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_zero  (div_zero)
    );

    // Reference: plain signed arithmetic plus the architectural rules for the corner cases.
    task automatic model_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] e_hi, output logic [31:0] e_lo,
                            output int e_lat, output logic e_dz);
        longint sa, sb, p, qv, rv;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        e_dz = 1'b0;
        if (is_mult) begin
            p     = sa * sb;
            e_hi  = p[63:32];
            e_lo  = p[31:0];
            e_lat = 33;
        end else if (b == 32'd0) begin
`ifdef MULTDIV_DIV0_TRAP_EN
            e_hi  = model_hi;
            e_lo  = model_lo;
            e_lat = 2;
            e_dz  = 1'b1;
`else
            e_hi  = a;
            e_lo  = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
            e_lat = 34;
`endif
        end else begin
            qv    = sa / sb;
            rv    = sa % sb;
            e_hi  = rv[31:0];
            e_lo  = qv[31:0];
            e_lat = 34;
        end
    endtask

    // Drives one operation from the current negedge; returns at the negedge after done.
    task automatic run_op(input logic do_mult, input logic do_div, input logic [31:0] a,
                          input logic [31:0] b, input int inject_div_at, input bit start_in_done,
                          output int lat, output int busy_cnt, output logic [31:0] hi,
                          output logic [31:0] lo, output logic dz, output logic done_after,
                          output logic busy_after);
        int cyc;
        cyc        = 0;
        lat        = -1;
        busy_cnt   = 0;
        hi         = '0;
        lo         = '0;
        dz         = 1'b0;
        a_in       = a;
        b_in       = b;
        mult_start = do_mult;
        div_start  = do_div;
        while (lat < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mult_start = 1'b0;
            div_start  = 1'b0;
            a_in       = $urandom;
            b_in       = $urandom;
            if (cyc == inject_div_at) div_start = 1'b1;
            if (done) begin
                lat = cyc;
                hi  = hi_out;
                lo  = lo_out;
                dz  = div_zero;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        if (start_in_done && lat > 0) mult_start = 1'b1;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        done_after = done;
        busy_after = busy;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (div_zero !== 1'b0) $display("FAIL reset_dz: got %b want 0", div_zero); else pass_cnt++;
        total_cnt++;
        if (hi_out !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi_out); else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo_out); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat, bc; logic [31:0] hi, lo; logic dz, da, ba;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (lat !== 33) $display("FAIL mult_lat: got %0d want 33", lat); else pass_cnt++;
        total_cnt++;
        if (bc !== 32) $display("FAIL mult_busy: got %0d want 32", bc); else pass_cnt++;
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", hi);
        else pass_cnt++;
        total_cnt++;
        if (lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h want ffffffeb", lo);
        else pass_cnt++;
        total_cnt++;
        if (da !== 1'b0) $display("FAIL done_pulse: got %b want 0", da); else pass_cnt++;
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (hi !== 32'h4000_0000) $display("FAIL mult_min_hi: got %h want 40000000", hi);
        else pass_cnt++;
        total_cnt++;
        if (lo !== 32'h0) $display("FAIL mult_min_lo: got %h want 0", lo); else pass_cnt++;
        model_hi = 32'h4000_0000; model_lo = 32'h0;
    endtask

    task automatic test_div();
        int lat, bc; logic [31:0] hi, lo; logic dz, da, ba;
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (lat !== 34) $display("FAIL div_lat: got %0d want 34", lat); else pass_cnt++;
        total_cnt++;
        if (bc !== 33) $display("FAIL div_busy: got %0d want 33", bc); else pass_cnt++;
        total_cnt++;
        if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", lo);
        else pass_cnt++;
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", hi);
        else pass_cnt++;
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h want 80000000", lo);
        else pass_cnt++;
        total_cnt++;
        if (hi !== 32'h0) $display("FAIL div_ovf_hi: got %h want 0", hi); else pass_cnt++;
        model_hi = 32'h0; model_lo = 32'h8000_0000;
    endtask

    task automatic test_div_zero();
        int lat, bc; logic [31:0] hi, lo; logic dz, da, ba;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
`ifdef MULTDIV_DIV0_TRAP_EN
        total_cnt++;
        if (lat !== 2) $display("FAIL dz_lat: got %0d want 2", lat); else pass_cnt++;
        total_cnt++;
        if (dz !== 1'b1) $display("FAIL dz_flag: got %b want 1", dz); else pass_cnt++;
        total_cnt++;
        if (div_zero !== 1'b0) $display("FAIL dz_pulse: got %b want 0", div_zero);
        else pass_cnt++;
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF) $display("FAIL dz_hi: got %h want ffffffff", hi);
        else pass_cnt++;
        total_cnt++;
        if (lo !== 32'hFFFF_FFEB) $display("FAIL dz_lo: got %h want ffffffeb", lo);
        else pass_cnt++;
        model_hi = 32'hFFFF_FFFF; model_lo = 32'hFFFF_FFEB;
`else
        total_cnt++;
        if (lat !== 34) $display("FAIL dz_lat: got %0d want 34", lat); else pass_cnt++;
        total_cnt++;
        if (dz !== 1'b0) $display("FAIL dz_flag: got %b want 0", dz); else pass_cnt++;
        total_cnt++;
        if (lo !== 32'hFFFF_FFFF) $display("FAIL dz_lo: got %h want ffffffff", lo);
        else pass_cnt++;
        total_cnt++;
        if (hi !== 32'd5) $display("FAIL dz_hi: got %h want 5", hi); else pass_cnt++;
        run_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (lo !== 32'h1 || hi !== 32'hFFFF_FFFB)
            $display("FAIL dz_neg: got hi=%h lo=%h want hi=fffffffb lo=00000001", hi, lo);
        else pass_cnt++;
        model_hi = 32'hFFFF_FFFB; model_lo = 32'h1;
`endif
    endtask

    task automatic test_start_rules();
        int lat, bc, e_lat; logic [31:0] hi, lo, e_hi, e_lo; logic dz, da, ba, e_dz, seen;
        model_op(1'b1, 32'd123456, 32'hFFFF_FCEB, e_hi, e_lo, e_lat, e_dz);
        run_op(1'b1, 1'b1, 32'd123456, 32'hFFFF_FCEB, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (lat !== e_lat || hi !== e_hi || lo !== e_lo)
            $display("FAIL both_start: got lat=%0d %h_%h want lat=%0d %h_%h",
                     lat, hi, lo, e_lat, e_hi, e_lo);
        else pass_cnt++;
        model_op(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, e_hi, e_lo, e_lat, e_dz);
        run_op(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10, 1'b1, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (lat !== e_lat || hi !== e_hi || lo !== e_lo)
            $display("FAIL mid_start: got lat=%0d %h_%h want lat=%0d %h_%h",
                     lat, hi, lo, e_lat, e_hi, e_lo);
        else pass_cnt++;
        model_hi = e_hi; model_lo = e_lo;
        // mult_start was held through the DONE cycle; it must not have launched anything.
        total_cnt++;
        if (ba !== 1'b0) $display("FAIL done_start_busy: got %b want 0", ba); else pass_cnt++;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL done_start_ignored: got done=%b want 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_div();
        int lat, bc, e_lat; logic [31:0] hi, lo, e_hi, e_lo; logic dz, da, ba, e_dz, seen;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        a_in = 32'hFFFF_FFF9; b_in = 32'd2; div_start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            div_start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid_ctl: got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        total_cnt++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0)
            $display("FAIL rst_mid_res: got %h_%h want 0_0", hi_out, lo_out);
        else pass_cnt++;
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL rst_mid_nodone: got done=%b want 0", seen);
        else pass_cnt++;
        model_op(1'b1, 32'h0001_2345, 32'h8765_4321, e_hi, e_lo, e_lat, e_dz);
        run_op(1'b1, 1'b0, 32'h0001_2345, 32'h8765_4321, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
        total_cnt++;
        if (lat !== e_lat || hi !== e_hi || lo !== e_lo)
            $display("FAIL rst_mid_mult: got lat=%0d %h_%h want lat=%0d %h_%h",
                     lat, hi, lo, e_lat, e_hi, e_lo);
        else pass_cnt++;
        model_hi = e_hi; model_lo = e_lo;
    endtask

    task automatic test_random();
        int lat, bc, e_lat; logic [31:0] a, b, hi, lo, e_hi, e_lo; logic op, dz, da, ba, e_dz;
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = pick_operand();
            b  = pick_operand();
            model_op(op, a, b, e_hi, e_lo, e_lat, e_dz);
            run_op(op, ~op, a, b, 0, 1'b0, lat, bc, hi, lo, dz, da, ba);
            total_cnt++;
            if (lat !== e_lat || dz !== e_dz)
                $display("FAIL rand_ctl[%0d]: got lat=%0d dz=%b want lat=%0d dz=%b",
                         i, lat, dz, e_lat, e_dz);
            else pass_cnt++;
            total_cnt++;
            if (hi !== e_hi || lo !== e_lo)
                $display("FAIL rand_res[%0d] %s %h,%h: got %h_%h want %h_%h",
                         i, op ? "mul" : "div", a, b, hi, lo, e_hi, e_lo);
            else pass_cnt++;
            model_hi = e_hi; model_lo = e_lo;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_rules();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
